// File: rtl/bp_cfg_loader_if.sv
// Config-write bus between the boot-time loader (master) and the per-tile
// config registers (slave). Valid/ready handshake; a write completes on a
// cycle where cfg_v_o & cfg_ready_i.
interface bp_cfg_loader_if #(
    parameter int num_core_p       = 1,
    parameter int cfg_data_width_p = 8
);
    localparam int core_id_width_lp  = (num_core_p > 1) ? $clog2(num_core_p) : 1;
    localparam int cfg_addr_width_lp = 2;

    logic                         cfg_v_o;
    logic                         cfg_ready_i;
    logic [core_id_width_lp-1:0]  cfg_core_o;
    logic [cfg_addr_width_lp-1:0] cfg_addr_o;
    logic [cfg_data_width_p-1:0]  cfg_data_o;

    modport master (
        output cfg_v_o,
        output cfg_core_o,
        output cfg_addr_o,
        output cfg_data_o,
        input  cfg_ready_i
    );

    modport slave (
        input  cfg_v_o,
        input  cfg_core_o,
        input  cfg_addr_o,
        input  cfg_data_o,
        output cfg_ready_i
    );
endinterface

// File: rtl/bp_cfg_loader.sv
// Boot-time configuration sequencer for the core-complex grid.
// On start it freezes and programs every core (freeze, hart id, icache mode,
// dcache mode), then unfreezes cores 0..N-1 in order and pulses done_o.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | waiting for start_i; bus idle, busy_o low
// S_PROGRAM  | writing reg_cnt of core core_cnt (addr 0..3 per core)
// S_UNFREEZE | writing freeze=0 to core core_cnt
// S_DONE     | one-cycle done_o pulse, start_i ignored
module bp_cfg_loader #(
    parameter int num_core_p       = 1,
    parameter int cfg_data_width_p = 8
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          start_i,
    input  logic [cfg_data_width_p-1:0]   icache_mode_i,
    input  logic [cfg_data_width_p-1:0]   dcache_mode_i,
    bp_cfg_loader_if.master               cfg,
    output logic                          busy_o,
    output logic                          done_o
);
    localparam int core_id_width_lp  = (num_core_p > 1) ? $clog2(num_core_p) : 1;
    localparam int cfg_addr_width_lp = 2;

    if (num_core_p < 1) begin : g_bad_num_core
        $error("bp_cfg_loader: num_core_p must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_PROGRAM,
        S_UNFREEZE,
        S_DONE
    } state_e;

    state_e                        state_r;
    state_e                        state_n;
    logic [core_id_width_lp-1:0]   core_cnt;
    logic [cfg_addr_width_lp-1:0]  reg_cnt;
    logic [cfg_data_width_p-1:0]   icache_r;
    logic [cfg_data_width_p-1:0]   dcache_r;

    logic                          cfg_v;
    logic [core_id_width_lp-1:0]   cfg_core;
    logic [cfg_addr_width_lp-1:0]  cfg_addr;
    logic [cfg_data_width_p-1:0]   cfg_data;

    logic                          cfg_hs;
    logic                          last_core;
    logic                          last_reg;
    logic                          start_accept;

    // Explicit compare keeps core_cnt inside 0..num_core_p-1 for any count.
    assign last_core    = (core_cnt == core_id_width_lp'(num_core_p - 1));
    assign last_reg     = (reg_cnt == 2'd3);
    assign cfg_hs       = cfg_v & cfg.cfg_ready_i;
    assign start_accept = (state_r == S_IDLE) & start_i;

    // State register; reset aborts any sequence immediately.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state decode; transitions only on a completed handshake.
    always_comb begin
        state_n = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_i) state_n = S_PROGRAM;
            end
            S_PROGRAM: begin
                if (cfg_hs && last_reg && last_core) state_n = S_UNFREEZE;
            end
            S_UNFREEZE: begin
                if (cfg_hs && last_core) state_n = S_DONE;
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Core/register counters and captured mode values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            core_cnt <= '0;
            reg_cnt  <= '0;
            icache_r <= '0;
            dcache_r <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start_i) begin
                        core_cnt <= '0;
                        reg_cnt  <= '0;
                        icache_r <= icache_mode_i;
                        dcache_r <= dcache_mode_i;
                    end
                end
                S_PROGRAM: begin
                    if (cfg_hs) begin
                        reg_cnt <= reg_cnt + 2'd1;
                        if (last_reg) begin
                            core_cnt <= last_core ? '0 : core_cnt + core_id_width_lp'(1);
                        end
                    end
                end
                S_UNFREEZE: begin
                    if (cfg_hs) begin
                        core_cnt <= last_core ? '0 : core_cnt + core_id_width_lp'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode from registered state only, so fields cannot move while stalled.
    always_comb begin
        cfg_v    = 1'b0;
        cfg_core = '0;
        cfg_addr = '0;
        cfg_data = '0;
        busy_o   = (state_r != S_IDLE);
        done_o   = (state_r == S_DONE);
        case (state_r)
            S_PROGRAM: begin
                cfg_v    = 1'b1;
                cfg_core = core_cnt;
                cfg_addr = reg_cnt;
                case (reg_cnt)
                    2'd0:    cfg_data = cfg_data_width_p'(1);
                    2'd1:    cfg_data = cfg_data_width_p'(core_cnt);
                    2'd2:    cfg_data = icache_r;
                    default: cfg_data = dcache_r;
                endcase
            end
            S_UNFREEZE: begin
                cfg_v    = 1'b1;
                cfg_core = core_cnt;
            end
            default: ;
        endcase
    end

    assign cfg.cfg_v_o    = cfg_v;
    assign cfg.cfg_core_o = cfg_core;
    assign cfg.cfg_addr_o = cfg_addr;
    assign cfg.cfg_data_o = cfg_data;

    a_no_start_while_busy: assert property (
        @(posedge clk_i) disable iff (reset_i) busy_o |-> !start_accept
    );
endmodule
